// File: rtl/debounce_pkg.sv
// Shared types and defaults for the debounce input stage.
// Optional feature macro: DEBOUNCE_EDGE_EN (rise_o/fall_o strobes).
package debounce_pkg;

  localparam int unsigned DEBOUNCE_STABLE_CYCLES_DEF = 4;

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous level.
// Reusable by any input stage in the clk domain.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  // shift the raw level through two stages
  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  // synchronizer registers, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/debounce.sv
// Debounce stage: sync, then accept a level after STABLE_CYCLES mismatches.
// Optional feature macro: DEBOUNCE_EDGE_EN (rise_o/fall_o strobes).
module debounce
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEBOUNCE_STABLE_CYCLES_DEF,
  parameter int unsigned CNT_W = $clog2(STABLE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             in_s;
  state_e           state;
  logic             acc;
  logic             out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (in),
    .q   (in_s)
  );

  // state is implied by whether the synced level disagrees with out
  always_comb begin
    state = (in_s != out_q) ? ST_PENDING : ST_STABLE;
  end

  // count consecutive mismatches; accept on the last one
  always_comb begin
    cnt_d = '0;
    out_d = out_q;
    acc   = 1'b0;
    unique case (state)
      ST_STABLE: begin
        cnt_d = '0;
      end
      ST_PENDING: begin
        if (cnt_q == CNT_LAST) begin
          out_d = in_s;
          acc   = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  // debounced level and mismatch counter
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      out_q <= out_d;
      cnt_q <= cnt_d;
    end
  end

  assign out = out_q;

`ifdef DEBOUNCE_EDGE_EN
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  // strobes fire with the accepted change
  always_comb begin
    rise_d = acc & in_s;
    fall_d = acc & ~in_s;
  end

  // strobe registers align with out
  always_ff @(posedge clk) begin
    if (rst) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
`else
  assign rise_o = 1'b0;
  assign fall_o = 1'b0;
`endif

endmodule

// File: tb/tb_debounce.sv
// Self-checking bench for debounce with a window-based reference model.
// Strobe expectations follow DEBOUNCE_EDGE_EN.
module tb_debounce;

  localparam int SC = 4;
`ifdef DEBOUNCE_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_r = 1'b0;
  logic out_w, rise_w, fall_w;

  int checks = 0;
  int failures = 0;

  debounce #(.STABLE_CYCLES(SC)) dut (
    .clk    (clk),
    .rst    (rst),
    .in     (in_r),
    .out    (out_w),
    .rise_o (rise_w),
    .fall_o (fall_w)
  );

  always #5 clk = ~clk;

  // Reference: remember synced samples seen since the last reset or
  // accepted change; accept when the newest SC all disagree with out.
  logic m_s1, m_s2, m_out, m_rise, m_fall;
  logic win[$];
  bit   all_diff;

  always @(posedge clk) begin
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_out = 0;
      m_rise = 0; m_fall = 0;
      win.delete();
    end else begin
      m_rise = 0; m_fall = 0;
      win.push_back(m_s2);
      if (win.size() > SC) void'(win.pop_front());
      all_diff = (win.size() == SC);
      foreach (win[i]) if (win[i] == m_out) all_diff = 0;
      if (all_diff) begin
        m_out = ~m_out;
        m_rise = EDGE_EN & m_out;
        m_fall = EDGE_EN & ~m_out;
        win.delete();
      end
      m_s2 = m_s1;
      m_s1 = in_r;
    end
  end

  task automatic tick(input logic v);
    in_r = v;
    @(negedge clk);
  endtask

  task automatic settle(input logic v);
    for (int i = 0; i < 12; i++) tick(v);
  endtask

  task automatic test_reset;
    rst = 1;
    for (int k = 0; k < 2; k++) begin
      tick(1);
      checks++;
      if ({out_w, rise_w, fall_w} !== 3'b000) begin
        failures++;
        $display("FAIL reset_hold got=%b exp=000", {out_w, rise_w, fall_w});
      end
    end
    rst = 0;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      checks++;
      if (out_w !== (k >= 6) || out_w !== m_out) begin
        failures++;
        $display("FAIL reset_requal k=%0d got=%b exp=%b", k, out_w, k >= 6);
      end
      checks++;
      if (rise_w !== (EDGE_EN && k == 6)) begin
        failures++;
        $display("FAIL reset_rise k=%0d got=%b exp=%b", k, rise_w,
                 EDGE_EN && k == 6);
      end
    end
  endtask

  task automatic test_clean_step;
    settle(0);
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      checks++;
      if (out_w !== (k >= 6) || out_w !== m_out) begin
        failures++;
        $display("FAIL step_up k=%0d got=%b exp=%b", k, out_w, k >= 6);
      end
      checks++;
      if ({rise_w, fall_w} !== {EDGE_EN && k == 6, 1'b0}) begin
        failures++;
        $display("FAIL step_up_strobe k=%0d got=%b%b", k, rise_w, fall_w);
      end
    end
    for (int k = 1; k <= 20; k++) begin
      tick(0);
      checks++;
      if (out_w !== (k < 6) || out_w !== m_out) begin
        failures++;
        $display("FAIL step_dn k=%0d got=%b exp=%b", k, out_w, k < 6);
      end
      checks++;
      if ({rise_w, fall_w} !== {1'b0, EDGE_EN && k == 6}) begin
        failures++;
        $display("FAIL step_dn_strobe k=%0d got=%b%b", k, rise_w, fall_w);
      end
    end
  endtask

  task automatic test_glitch;
    int rises;
    int hi;
    settle(0);
    for (int k = 0; k < 18; k++) begin
      tick(k < 3);
      checks++;
      if ({out_w, rise_w, fall_w} !== 3'b000 || out_w !== m_out) begin
        failures++;
        $display("FAIL glitch3 k=%0d got=%b exp=000", k,
                 {out_w, rise_w, fall_w});
      end
    end
    rises = 0;
    hi = 0;
    for (int k = 0; k < 18; k++) begin
      tick(k < 4);
      rises += int'(rise_w);
      hi += int'(out_w);
      checks++;
      if ({out_w, rise_w, fall_w} !== {m_out, m_rise, m_fall}) begin
        failures++;
        $display("FAIL glitch4_model k=%0d got=%b exp=%b", k,
                 {out_w, rise_w, fall_w}, {m_out, m_rise, m_fall});
      end
    end
    checks++;
    if (hi < 1 || rises != int'(EDGE_EN)) begin
      failures++;
      $display("FAIL glitch4 hi=%0d rises=%0d exp_rises=%0d", hi, rises,
               EDGE_EN);
    end
  endtask

  task automatic test_bounce;
    logic seq[5] = '{1, 0, 1, 0, 1};
    int first_hi;
    int toggles;
    int rises;
    logic prev;
    settle(0);
    first_hi = -1;
    toggles = 0;
    rises = 0;
    prev = out_w;
    for (int k = 1; k <= 20; k++) begin
      tick(k <= 5 ? seq[k-1] : 1'b1);
      if (out_w !== prev) toggles++;
      if (out_w === 1'b1 && first_hi < 0) first_hi = k;
      prev = out_w;
      rises += int'(rise_w);
      checks++;
      if (out_w !== m_out) begin
        failures++;
        $display("FAIL bounce_model k=%0d got=%b exp=%b", k, out_w, m_out);
      end
    end
    checks++;
    if (first_hi != 10 || toggles != 1 || rises != int'(EDGE_EN)) begin
      failures++;
      $display("FAIL bounce first=%0d exp=10 toggles=%0d rises=%0d",
               first_hi, toggles, rises);
    end
  endtask

  task automatic test_reset_mid_count;
    settle(0);
    tick(1);
    tick(1);
    rst = 1;
    tick(1);
    checks++;
    if ({out_w, rise_w, fall_w} !== 3'b000) begin
      failures++;
      $display("FAIL midrst_hold got=%b exp=000", {out_w, rise_w, fall_w});
    end
    rst = 0;
    for (int k = 1; k <= 9; k++) begin
      tick(1);
      checks++;
      if (out_w !== (k >= 6) || out_w !== m_out) begin
        failures++;
        $display("FAIL midrst k=%0d got=%b exp=%b", k, out_w, k >= 6);
      end
    end
  endtask

  task automatic test_random;
    logic v;
    int left;
    v = 0;
    left = 0;
    for (int k = 0; k < 400; k++) begin
      if (left == 0) begin
        v = ~v;
        left = int'($urandom_range(1, 7));
      end
      left--;
      tick(v);
      checks++;
      if ({out_w, rise_w, fall_w} !== {m_out, m_rise, m_fall}
          || (rise_w && fall_w)) begin
        failures++;
        $display("FAIL random k=%0d got=%b exp=%b", k,
                 {out_w, rise_w, fall_w}, {m_out, m_rise, m_fall});
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_clean_step();
    test_glitch();
    test_bounce();
    test_reset_mid_count();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
